// File: rtl/cp_insert_ctrl.sv
// Cyclic-prefix insertion sequencer. Fills a symbol BRAM with N samples, then
// replays the last C samples (prefix) followed by all N samples. Reads are
// issued only when the 2-entry output skid has room for them, so any m_ready
// pattern is absorbed without losing or repeating samples.
module cp_insert_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   cfg_fft_len,
  input  logic [ADDR_W-1:0] cfg_cp_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_cp_flag,
  output logic              m_last,
  output logic              cfg_err,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
);

  typedef enum logic [1:0] {IDLE, FILL, CP, BODY} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              cp;
    logic              last;
  } beat_t;

  localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [ADDR_W:0]   rcnt_q, rcnt_d;
  logic              s_ready_q, s_ready_d;
  logic              cfg_err_q, cfg_err_d;
  logic              rd_vld_q, rd_cp_q, rd_last_q;
  logic              rd_vld_d, rd_cp_d, rd_last_d;
  beat_t             fifo_q [2];
  beat_t             fifo_d [2];
  logic [1:0]        cnt_q, cnt_d;

  logic              wr_go, rd_go, slot_free, pop, cfg_ok;
  logic [ADDR_W:0]   phase_len, rd_addr;
  beat_t             inflight, head;

  // Read issue: prefix walks N-C..N-1, body walks 0..N-1, gated by skid room
  always_comb begin
    phase_len = (state_q == CP) ? {1'b0, c_q} : n_q;
    rd_addr   = (state_q == CP) ? (n_q - {1'b0, c_q} + rcnt_q) : rcnt_q;
    slot_free = (cnt_q + {1'b0, rd_vld_q}) < 2'd2;
    rd_go     = ((state_q == CP) || (state_q == BODY)) && (rcnt_q < phase_len) && slot_free;
    wr_go     = (state_q == FILL) && s_valid && s_ready_q;
    cfg_ok    = (cfg_fft_len != '0) && (cfg_fft_len <= MAX_N) && ({1'b0, cfg_cp_len} < cfg_fft_len);
  end

  // Output head: oldest skid entry, else the BRAM word arriving this cycle
  always_comb begin
    inflight  = '{data: bram_doutb, cp: rd_cp_q, last: rd_last_q};
    head      = (cnt_q != 2'd0) ? fifo_q[0] : inflight;
    m_valid   = (cnt_q != 2'd0) || rd_vld_q;
    m_data    = head.data;
    m_cp_flag = m_valid && head.cp;
    m_last    = m_valid && head.last;
    pop       = m_valid && m_ready;
  end

  // Skid update: pop from the front, park an unconsumed in-flight word at the back
  always_comb begin
    fifo_d    = fifo_q;
    cnt_d     = cnt_q;
    rd_vld_d  = rd_go;
    rd_cp_d   = (state_q == CP);
    rd_last_d = (state_q == BODY) && (rcnt_q == n_q - ONE);
    if (pop && (cnt_q != 2'd0)) begin
      fifo_d[0] = fifo_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (rd_vld_q && !(pop && (cnt_q == 2'd0))) begin
      fifo_d[cnt_d[0]] = inflight;
      cnt_d            = cnt_d + 2'd1;
    end
  end

  // Sequencer: config latch, fill counting, prefix/body read counting
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    c_d       = c_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    s_ready_d = s_ready_q;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        n_d    = cfg_fft_len;
        c_d    = cfg_cp_len;
        wcnt_d = '0;
        rcnt_d = '0;
        if (cfg_ok) begin
          state_d   = FILL;
          s_ready_d = 1'b1;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
      FILL: begin
        if (wr_go) begin
          wcnt_d = wcnt_q + ONE;
          if (wcnt_q == n_q - ONE) begin
            s_ready_d = 1'b0;
            state_d   = (c_q != '0) ? CP : BODY;
          end
        end
      end
      CP: begin
        if (rd_go) begin
          rcnt_d = rcnt_q + ONE;
          if (rcnt_q == {1'b0, c_q} - ONE) begin
            rcnt_d  = '0;
            state_d = BODY;
          end
        end
      end
      default: begin
        if (rd_go) rcnt_d = rcnt_q + ONE;
        if (pop && head.last) state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      c_q       <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      s_ready_q <= 1'b0;
      cfg_err_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_cp_q   <= 1'b0;
      rd_last_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      c_q       <= c_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      s_ready_q <= s_ready_d;
      cfg_err_q <= cfg_err_d;
      rd_vld_q  <= rd_vld_d;
      rd_cp_q   <= rd_cp_d;
      rd_last_q <= rd_last_d;
      fifo_q    <= fifo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign cfg_err    = cfg_err_q;
  assign bram_wea   = wr_go;
  assign bram_addra = wcnt_q[ADDR_W-1:0];
  assign bram_dina  = s_data;
  assign bram_enb   = rd_go;
  assign bram_addrb = rd_go ? rd_addr[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_cp_insert_ctrl.sv
// Scoreboard bench for cp_insert_ctrl with a behavioural BRAM.
module tb_cp_insert_ctrl;
  localparam int DW = 32;
  localparam int AW = 13;
  localparam int TO = 40000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   cfg_fft_len;
  logic [AW-1:0] cfg_cp_len;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_cp_flag, m_last, cfg_err;
  logic          bram_wea, bram_enb;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [DW-1:0] bram_dina, bram_doutb;

  cp_insert_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cfg_fft_len(cfg_fft_len), .cfg_cp_len(cfg_cp_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_cp_flag(m_cp_flag), .m_last(m_last), .cfg_err(cfg_err),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb));

  always #5 clk = ~clk;

  // Symbol memory: write-through on port A, registered read on port B
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  typedef struct {logic [DW-1:0] d; logic cp; logic last;} exp_t;
  typedef struct {int n; int c; bit rdata; bit rrdy; bit gap; int abort_at;} sym_t;

  exp_t sbq[$];
  int   errs = 0, checks = 0, wea_cnt = 0;
  bit   rdy_rand = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Downstream ready: held high or random 50%
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability
  initial begin
    bit prev_stall = 1'b0;
    logic [DW+1:0] prev = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bram_wea) wea_cnt++;
      if (rst) prev_stall = 1'b0;
      else begin
        if (prev_stall)
          chk(m_valid && ({m_cp_flag, m_last, m_data} == prev), "hold",
              {m_valid, m_cp_flag, m_last, m_data}, {1'b1, prev});
        if (m_valid && m_ready) begin
          if (sbq.size() == 0) chk(1'b0, "unexpected_beat", {m_cp_flag, m_last, m_data}, 0);
          else begin
            e = sbq.pop_front();
            chk(m_data === e.d && m_cp_flag === e.cp && m_last === e.last, "beat",
                {m_cp_flag, m_last, m_data}, {e.cp, e.last, e.d});
          end
        end
        prev_stall = m_valid && !m_ready;
        prev = {m_cp_flag, m_last, m_data};
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!s_ready && t < TO) begin @(posedge clk); #1; t++; end
    ok = s_ready;
    if (!ok) chk(1'b0, "s_ready_timeout", 0, 1);
  endtask

  task automatic run_sym(input sym_t s, input sym_t nxt);
    logic [DW-1:0] smp[$];
    bit ok;
    int t, vc;
    exp_t e;
    rdy_rand = s.rrdy;
    wait_ready(ok);
    if (!ok) return;
    cfg_fft_len = (AW+1)'(nxt.n);
    cfg_cp_len  = AW'(nxt.c);
    for (int i = 0; i < s.n; i++) smp.push_back(s.rdata ? $urandom : DW'(i));
    for (int i = 0; i < s.n; i++) begin
      if (i == s.abort_at) begin
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        chk(!s_ready && !m_valid && !m_cp_flag && !m_last && !cfg_err && !bram_wea && !bram_enb
            && bram_addra == 0 && bram_addrb == 0, "reset_mid",
            {s_ready, m_valid, m_cp_flag, m_last, cfg_err, bram_wea, bram_enb}, 0);
        rst = 1'b0;
        return;
      end
      if (s.rdata && $urandom_range(0, 3) == 0) begin s_valid = 1'b0; @(posedge clk); #1; end
      s_data = smp[i]; s_valid = 1'b1;
      wait_ready(ok);
      if (!ok) return;
      if (i == s.n - 1) begin
        for (int k = 0; k < s.c; k++) begin
          e.d = smp[s.n - s.c + k]; e.cp = 1'b1; e.last = 1'b0; sbq.push_back(e);
        end
        for (int k = 0; k < s.n; k++) begin
          e.d = smp[k]; e.cp = 1'b0; e.last = (k == s.n - 1); sbq.push_back(e);
        end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
    end
    if (s.gap) begin
      chk(!m_valid, "latency_early", m_valid, 0);
      @(posedge clk); #1;
      chk(m_valid, "latency_2", m_valid, 1);
      vc = 0;
      repeat (s.c + s.n) begin
        if (m_valid) vc++;
        @(posedge clk); #1;
      end
      chk(vc == s.c + s.n && !m_valid, "gapless_beats", vc, s.c + s.n);
      @(posedge clk); #1;
      chk(s_ready, "s_ready_again", s_ready, 1);
    end
    t = 0;
    while (sbq.size() != 0 && t < TO) begin @(posedge clk); #1; t++; end
    chk(sbq.size() == 0, "drain", sbq.size(), 0);
  endtask

  initial begin
    sym_t syms[$];
    sym_t nxt;
    int n;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_fft_len = 4; cfg_cp_len = 4;
    s_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(!s_ready && !m_valid && !m_cp_flag && !m_last && !cfg_err && !bram_wea && !bram_enb
        && bram_addra == 0 && bram_addrb == 0, "reset_state",
        {s_ready, m_valid, m_cp_flag, m_last, cfg_err, bram_wea, bram_enb}, 0);
    rst = 1'b0;
    // Invalid configs: C==N, then N==0; each rejected with cfg_err
    @(posedge clk); #1;
    chk(cfg_err && !s_ready, "cfg_err_c_eq_n", {cfg_err, s_ready}, 2'b10);
    cfg_fft_len = 0; cfg_cp_len = 0;
    @(posedge clk); #1;
    chk(cfg_err && !s_ready, "cfg_err_n0", {cfg_err, s_ready}, 2'b10);
    s_valid = 1'b0;
    cfg_fft_len = 8; cfg_cp_len = 2;
    @(posedge clk); #1;
    chk(!cfg_err && s_ready, "cfg_ok", {cfg_err, s_ready}, 2'b01);
    chk(wea_cnt == 0, "no_write_on_bad_cfg", wea_cnt, 0);

    syms.push_back('{8, 2, 1'b0, 1'b0, 1'b1, -1});
    syms.push_back('{8, 0, 1'b0, 1'b0, 1'b1, -1});
    syms.push_back('{16, 4, 1'b1, 1'b1, 1'b0, -1});
    syms.push_back('{8, 2, 1'b0, 1'b0, 1'b0, 5});
    syms.push_back('{8, 2, 1'b0, 1'b0, 1'b1, -1});
    syms.push_back('{1, 0, 1'b1, 1'b1, 1'b0, -1});
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 40);
      syms.push_back('{n, int'($urandom_range(0, n - 1)), 1'b1, 1'b1, 1'b0, -1});
    end
    syms.push_back('{1 << AW, (1 << AW) - 1, 1'b1, 1'b0, 1'b1, -1});

    for (int i = 0; i < syms.size(); i++) begin
      nxt = (i + 1 < syms.size()) ? syms[i + 1] : '{8, 0, 1'b0, 1'b0, 1'b0, -1};
      run_sym(syms[i], nxt);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
